fix_mac_pipe: RTL and testbench

- Pipelined signed fixed-point multiply-accumulate engine for the CNN datapath.
- Successor to the single-product fixed-point multiplier, generalised in three ways:
  - parametrised word and fraction widths;
  - multi-beat dot-product accumulation with guard bits;
  - round/saturate back to WIDTH, with valid/ready flow control on both sides.
- Sits between the feature/weight stream readers and the activation stage.

---
 rtl/fix_mac_if.sv | 26 ++
 rtl/fix_mac_pipe.sv | 130 +++++++++++++
 tb/tb_fix_mac_pipe.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/fix_mac_if.sv
// Stream bundle for the fixed-point MAC: operand beats in, rounded frame results out.
// The slave modport is the engine; the master modport is whoever feeds and drains it.
interface fix_mac_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_sat;
    logic             busy;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_sat, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_data, out_sat, busy
    );
endinterface

// File: rtl/fix_mac_pipe.sv
// Three-stage signed fixed-point multiply-accumulate with round/saturate back to WIDTH.
// Optional macro FIX_MAC_ROUND_EN: round half up before the shift instead of truncating.
module fix_mac_pipe #(
    parameter int WIDTH       = 16,
    parameter int POINT_WIDTH = 8,
    parameter int ACC_GUARD   = 8
) (
    input  logic      clk,
    input  logic      rst,
    fix_mac_if.slave  bus
);
    localparam int PROD_W = 2 * WIDTH;
    localparam int ACC_W  = PROD_W + ACC_GUARD;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic                     en;

    logic                     s1_valid_reg;
    logic                     s1_last_reg;
    logic signed [WIDTH-1:0]  s1_a_reg;
    logic signed [WIDTH-1:0]  s1_b_reg;

    logic                     s2_valid_reg;
    logic                     s2_last_reg;
    logic signed [PROD_W-1:0] s2_prod_reg;

    logic signed [ACC_W-1:0]  acc_reg;
    logic                     acc_open_reg;
    logic                     out_valid_reg;
    logic [WIDTH-1:0]         out_data_reg;
    logic                     out_sat_reg;

    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  round_term;
    logic signed [ACC_W-1:0]  sum_rounded;
    logic signed [ACC_W-1:0]  shifted;
    logic [WIDTH-1:0]         conv_data;
    logic                     conv_sat;

    // A held result blocks every stage, so a stalled beat can never overtake it.
    assign en = !(out_valid_reg && !bus.out_ready);

    assign bus.in_ready  = en;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_sat   = out_sat_reg;
    assign bus.busy      = s1_valid_reg || s2_valid_reg || acc_open_reg || out_valid_reg;

    assign prod_ext = {{ACC_GUARD{s2_prod_reg[PROD_W-1]}}, s2_prod_reg};
    assign sum      = acc_reg + prod_ext;

`ifdef FIX_MAC_ROUND_EN
    assign round_term = {{(ACC_W-POINT_WIDTH){1'b0}}, 1'b1, {(POINT_WIDTH-1){1'b0}}};
`else
    assign round_term = '0;
`endif

    assign sum_rounded = sum + round_term;
    assign shifted     = sum_rounded >>> POINT_WIDTH;

    always_comb begin
        conv_data = shifted[WIDTH-1:0];
        conv_sat  = 1'b0;
        if (shifted > SAT_MAX) begin
            conv_data = {1'b0, {(WIDTH-1){1'b1}}};
            conv_sat  = 1'b1;
        end else if (shifted < SAT_MIN) begin
            conv_data = {1'b1, {(WIDTH-1){1'b0}}};
            conv_sat  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
        end else if (en) begin
            s1_valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
                s1_last_reg <= bus.in_last;
                s1_a_reg    <= bus.in_a;
                s1_b_reg    <= bus.in_b;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_reg <= 1'b0;
            s2_last_reg  <= 1'b0;
            s2_prod_reg  <= '0;
        end else if (en) begin
            s2_valid_reg <= s1_valid_reg;
            s2_last_reg  <= s1_last_reg;
            s2_prod_reg  <= s1_a_reg * s1_b_reg;
        end
    end

    // A last beat reaching S3 while the old result is being taken replaces it in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg       <= '0;
            acc_open_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sat_reg   <= 1'b0;
        end else if (en) begin
            if (s2_valid_reg && s2_last_reg) begin
                acc_reg       <= '0;
                acc_open_reg  <= 1'b0;
                out_valid_reg <= 1'b1;
                out_data_reg  <= conv_data;
                out_sat_reg   <= conv_sat;
            end else begin
                if (s2_valid_reg) begin
                    acc_reg      <= sum;
                    acc_open_reg <= 1'b1;
                end
                if (bus.out_ready) begin
                    out_valid_reg <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_fix_mac_pipe.sv
// Directed bench for fix_mac_pipe (W=16, F=8) with hand-computed Q8.8 results.
// Rounding cases pick their expected value from FIX_MAC_ROUND_EN.
module tb_fix_mac_pipe;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fix_mac_if #(.WIDTH(16)) bus ();

    fix_mac_pipe #(
        .WIDTH(16),
        .POINT_WIDTH(8),
        .ACC_GUARD(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Called in the negedge drive window; returns at the negedge after acceptance.
    task automatic beat(input logic [15:0] a, input logic [15:0] b, input logic last);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            check("in_ready_wait", 32'(bus.in_ready), 32'd1);
            return;
        end
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_last  = last;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
    endtask

    task automatic expect_result(input string tag, input logic [15:0] exp_data, input logic exp_sat);
        int n;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_data"}, 32'(bus.out_data), 32'(exp_data));
        check({tag, "_sat"}, 32'(bus.out_sat), 32'(exp_sat));
        $display("result %s data=0x%04h sat=%0d", tag, bus.out_data, bus.out_sat);
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] rnd_pos;
        logic [15:0] rnd_neg;
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
`ifdef FIX_MAC_ROUND_EN
        rnd_pos = 16'h0001;
        rnd_neg = 16'h0000;
`else
        rnd_pos = 16'h0000;
        rnd_neg = 16'hFFFF;
`endif

        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_sat", 32'(bus.out_sat), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);

        // single beat 1.5*2.0, exact latency
        beat(16'h0180, 16'h0200, 1'b1);
        check("lat_t0_valid", 32'(bus.out_valid), 32'd0);
        check("lat_t0_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check("lat_t1_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check("lat_t2_valid", 32'(bus.out_valid), 32'd1);
        check("single_data", 32'(bus.out_data), 32'h0300);
        check("single_sat", 32'(bus.out_sat), 32'd0);
        $display("result single data=0x%04h sat=%0d", bus.out_data, bus.out_sat);
        @(negedge clk);
        check("single_drained", 32'(bus.out_valid), 32'd0);

        // 3-beat dot product followed immediately by a one-beat frame
        beat(16'h0100, 16'h0100, 1'b0);
        beat(16'h0200, 16'h0080, 1'b0);
        beat(16'hFF00, 16'h0040, 1'b1);
        beat(16'h0100, 16'h0100, 1'b1);
        @(negedge clk);
        check("dot_valid", 32'(bus.out_valid), 32'd1);
        check("dot_data", 32'(bus.out_data), 32'h01C0);
        $display("result dot data=0x%04h sat=%0d", bus.out_data, bus.out_sat);
        @(negedge clk);
        check("b2b_valid", 32'(bus.out_valid), 32'd1);
        check("b2b_data", 32'(bus.out_data), 32'h0100);
        $display("result b2b data=0x%04h sat=%0d", bus.out_data, bus.out_sat);
        @(negedge clk);
        check("b2b_drained", 32'(bus.out_valid), 32'd0);

        // saturation and the exact negative limit
        beat(16'h7F00, 16'h0200, 1'b1);
        expect_result("sat_pos", 16'h7FFF, 1'b1);
        beat(16'h8000, 16'h0200, 1'b1);
        expect_result("sat_neg", 16'h8000, 1'b1);
        beat(16'h8000, 16'h0100, 1'b1);
        expect_result("neg_limit", 16'h8000, 1'b0);

        // half-LSB products: truncation vs rounding
        beat(16'h0001, 16'h0080, 1'b1);
        expect_result("round_pos", rnd_pos, 1'b0);
        beat(16'hFFFF, 16'h0080, 1'b1);
        expect_result("round_neg", rnd_neg, 1'b0);

        // backpressure: result held, input stalled, then both delivered in order
        bus.out_ready = 1'b0;
        beat(16'h0100, 16'h0100, 1'b1);
        beat(16'h0200, 16'h0100, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            check("bp_hold_data", 32'(bus.out_data), 32'h0100);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        $display("result bp_first data=0x%04h sat=%0d", bus.out_data, bus.out_sat);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_second_valid", 32'(bus.out_valid), 32'd1);
        check("bp_second_data", 32'(bus.out_data), 32'h0200);
        $display("result bp_second data=0x%04h sat=%0d", bus.out_data, bus.out_sat);
        @(negedge clk);
        check("bp_drained", 32'(bus.out_valid), 32'd0);
        check("bp_idle", 32'(bus.busy), 32'd0);

        // asynchronous reset in the middle of an open frame
        beat(16'h0100, 16'h0100, 1'b0);
        beat(16'h0100, 16'h0100, 1'b0);
        @(negedge clk);
        check("open_busy", 32'(bus.busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("post_rst_busy", 32'(bus.busy), 32'd0);
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        beat(16'h0200, 16'h0100, 1'b1);
        expect_result("after_rst", 16'h0200, 1'b0);

        repeat (3) @(negedge clk);
        check("final_idle", 32'(bus.busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
